cdc_event_arb: RTL

CDC_EVENT_ARB -- requirements
Module: cdc_event_arb

---
 rtl/cdc_event_arb_pkg.sv | 16 +
 rtl/rr_pick.sv | 30 +++
 rtl/cdc_event_arb.sv | 80 ++++++++
 3 files changed

// File: rtl/cdc_event_arb_pkg.sv
// Shared definitions for the event arbiter in front of a cdc_event synchronizer:
// state encoding and requester-index width derivation.
package cdc_event_arb_pkg;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_HOLD = 1'b1
    } state_t;

    localparam int CNT_W = 8;

    function automatic int calc_idw(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: the first set request at or after
// (last_grant+1) mod N, wrapping around.
module rr_pick #(
    parameter int N   = 4,
    parameter int IDW = 2
) (
    input  logic [N-1:0]   req,
    input  logic [IDW-1:0] last_grant,
    output logic           valid,
    output logic [IDW-1:0] index
);

    int j;

    // NOTE: every signal written in always_comb gets a default first so no latch is inferred.
    always_comb begin
        valid = 1'b0;
        index = '0;
        j     = 0;
        // Walk from the lowest priority up so the highest-priority hit is written last.
        for (int k = N; k >= 1; k--) begin
            j = (int'(last_grant) + k) % N;
            if (req[j]) begin
                valid = 1'b1;
                index = IDW'(j);
            end
        end
    end

endmodule

// File: rtl/cdc_event_arb.sv
// Funnels N single-cycle event requesters into one cdc_event source pulse,
// spacing issued events by a guard window that covers the req/ack round trip.
module cdc_event_arb
    import cdc_event_arb_pkg::*;
#(
    parameter int N    = 4,
    parameter int HOLD = 8
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic [N-1:0]           src_event,
    input  logic [N-1:0]           ovf_clr,
    output logic                   ev_out,
    output logic [calc_idw(N)-1:0] ev_id,
    output logic                   busy,
    output logic [N-1:0]           pending,
    output logic [N-1:0]           ovf
);

    localparam int IDW = calc_idw(N);

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic [IDW-1:0]   last_grant;
    logic             pick_valid;
    logic [IDW-1:0]   pick_idx;
    logic [N-1:0]     grant_mask;

    rr_pick #(.N(N), .IDW(IDW)) u_rr_pick (
        .req        (pending),
        .last_grant (last_grant),
        .valid      (pick_valid),
        .index      (pick_idx)
    );

    always_comb begin
        grant_mask = '0;
        if (state == ST_IDLE && pick_valid)
            grant_mask = N'(1) << pick_idx;
    end

    assign busy = (state == ST_HOLD);

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= ST_IDLE;
            ev_out     <= 1'b0;
            ev_id      <= '0;
            cnt        <= '0;
            pending    <= '0;
            ovf        <= '0;
            last_grant <= IDW'(N - 1);
        end else begin
            ev_out  <= 1'b0;
            // A new event on the grant edge re-arms the bit and is not an overflow.
            pending <= (pending & ~grant_mask) | src_event;
            ovf     <= (ovf & ~ovf_clr) | (src_event & pending & ~grant_mask);
            case (state)
                ST_IDLE: begin
                    if (pick_valid) begin
                        state      <= ST_HOLD;
                        ev_out     <= 1'b1;
                        ev_id      <= pick_idx;
                        last_grant <= pick_idx;
                        cnt        <= CNT_W'(HOLD - 1);
                    end
                end
                ST_HOLD: begin
                    if (cnt == '0)
                        state <= ST_IDLE;
                    else
                        cnt <= cnt - 1'b1;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule
